// File: rtl/inst_mem_prefetch.sv
// inst_mem_prefetch: instruction memory with a host-load phase and a run phase.
// In run phase the current and the next sequential word are read every cycle,
// so straight-line code is served without stalls after the first fetch.
module inst_mem_prefetch #(
  parameter int unsigned AW       = 12,
  parameter int unsigned DW       = 32,
  parameter bit          PREFETCH = 1'b1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW:0]      i_waddr,
  input  logic [DW-1:0]    i_wdata,
  input  logic             i_init_done,
  input  logic [AW-1:0]    i_iaddr,
  output logic [DW-1:0]    o_idata,
  output logic             o_halt,
  output logic             o_run,
  output logic [AW:0]      o_load_cnt,
  output logic             o_load_err,
  output logic [CNT_W-1:0] o_halt_cnt
);

  localparam int unsigned Depth   = 1 << AW;
  localparam logic [AW:0] LoadMax = {1'b1, {AW{1'b0}}};

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e           state_q;
  logic [DW-1:0]    mem_q [Depth];
  logic [DW-1:0]    rdata_a_q;
  logic [DW-1:0]    rdata_b_q;
  logic [AW-1:0]    addra_q;
  logic [AW-1:0]    addrb_q;
  logic             vld_q;
  logic [AW:0]      load_cnt_q;
  logic             load_err_q;
  logic [CNT_W-1:0] halt_cnt_q;

  logic [AW-1:0]    iaddr_nxt;
  logic             wr_ok;
  logic             hit_a;
  logic             hit_b;

  // Successor wraps naturally at DEPTH-1 -> 0.
  assign iaddr_nxt = i_iaddr + AW'(1);
  assign wr_ok     = !i_rst && (state_q == StLoad) && i_we && !i_waddr[AW];

  // Storage: host write port plus two synchronous read ports; never reset.
  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      mem_q[i_waddr[AW-1:0]] <= i_wdata;
    end
    rdata_a_q <= mem_q[i_iaddr];
    rdata_b_q <= mem_q[iaddr_nxt];
  end

  // Phase FSM, fetch address tracking and host-visible counters/flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StLoad;
      vld_q      <= 1'b0;
      addra_q    <= '0;
      addrb_q    <= '0;
      load_cnt_q <= '0;
      load_err_q <= 1'b0;
      halt_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          vld_q <= 1'b0;
          if (i_we) begin
            if (i_waddr[AW]) begin
              load_err_q <= 1'b1;
            end else if (load_cnt_q != LoadMax) begin
              load_cnt_q <= load_cnt_q + (AW+1)'(1);
            end
          end
          if (i_init_done) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          // Remember what the read ports fetched so next cycle can match on it.
          vld_q   <= 1'b1;
          addra_q <= i_iaddr;
          addrb_q <= iaddr_nxt;
          if (i_we) begin
            load_err_q <= 1'b1;
          end
          if (o_halt && (halt_cnt_q != '1)) begin
            halt_cnt_q <= halt_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  // Serve the fetch from whichever port read the requested address last cycle.
  always_comb begin
    hit_a   = vld_q && (i_iaddr == addra_q);
    hit_b   = PREFETCH && vld_q && !hit_a && (i_iaddr == addrb_q);
    o_halt  = !(hit_a || hit_b);
    o_idata = '0;
    if (hit_a) begin
      o_idata = rdata_a_q;
    end else if (hit_b) begin
      o_idata = rdata_b_q;
    end
  end

  assign o_run      = (state_q == StRun);
  assign o_load_cnt = load_cnt_q;
  assign o_load_err = load_err_q;
  assign o_halt_cnt = halt_cnt_q;

endmodule
